wb_burst_arbiter: RTL and testbench

WB_BURST_ARBITER -- requirements
Module: wb_burst_arbiter

---
 rtl/wb_burst_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_wb_burst_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_arbiter.sv
// Two-master Wishbone burst arbiter: round-robin on ties, latched burst
// length, beat counting, and a stalled-slave timeout that aborts with err.
module wb_burst_arbiter #(
    parameter int AW  = 24,
    parameter int DW  = 16,
    parameter int TMO = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_o,
    input  logic [1:0]    m0_sel,
    input  logic          m0_burst8,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_dat_i,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_o,
    input  logic [1:0]    m1_sel,
    input  logic          m1_burst4,
    input  logic          m1_burst8,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_dat_i,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    output logic [1:0]    s_sel,
    output logic [1:0]    s_burst,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic [DW-1:0] s_dat_i,

    output logic [1:0]    o_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] BL_1 = 2'd0;
    localparam logic [1:0] BL_4 = 2'd1;
    localparam logic [1:0] BL_8 = 2'd2;
    localparam logic [7:0] TMO_L = 8'(TMO);

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [1:0] r_blen;
    logic [3:0] r_beat;
    logic [7:0] r_tmo;

    logic       w_own0;
    logic       w_own1;
    logic       w_own;
    logic       w_cyc;
    logic       w_stb;
    logic       w_grant0;
    logic       w_grant1;
    logic [1:0] w_len0;
    logic [1:0] w_len1;
    logic [3:0] w_beat_inc;
    logic [3:0] w_beat_tgt;
    logic       w_tmo_hit;
    logic       w_burst_done;
    logic       w_release;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);
    assign w_own  = w_own0 | w_own1;
    assign w_cyc  = w_own1 ? m1_cyc : m0_cyc;
    assign w_stb  = w_own1 ? m1_stb : m0_stb;

    // r_last = 1 means m1 held the bus last, so m0 wins the next tie
    assign w_grant0 = m0_cyc & (~m1_cyc | r_last);
    assign w_grant1 = m1_cyc & (~m0_cyc | ~r_last);

    assign w_len0 = m0_burst8 ? BL_8 : BL_1;
    assign w_len1 = m1_burst8 ? BL_8 : (m1_burst4 ? BL_4 : BL_1);

    assign w_beat_inc = r_beat + 4'd1;
    assign w_beat_tgt = (r_blen == BL_8) ? 4'd8 : 4'd4;
    assign w_tmo_hit  = w_own & (r_tmo == TMO_L);

    assign w_burst_done = (r_blen != BL_1) & s_ack & ~w_tmo_hit &
                          (w_beat_inc == w_beat_tgt);

    assign w_release = w_own &
                       (~w_cyc | s_err | w_tmo_hit | w_burst_done);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                unique case (1'b1)
                    w_grant0: w_next = OWN0;
                    w_grant1: w_next = OWN1;
                    default:  w_next = IDLE;
                endcase
            end
            OWN0, OWN1: begin
                if (w_release) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last <= 1'b1;
            r_blen <= BL_1;
            r_beat <= 4'd0;
            r_tmo  <= 8'd0;
        end else if (!w_own) begin
            r_beat <= 4'd0;
            r_tmo  <= 8'd0;
            if (w_grant0) begin
                r_blen <= w_len0;
            end else if (w_grant1) begin
                r_blen <= w_len1;
            end
        end else begin
            if (w_release) begin
                r_last <= w_own1;
            end
            if (s_ack && !w_tmo_hit) begin
                r_beat <= w_beat_inc;
            end
            if (w_stb && !s_ack && !s_err && !w_tmo_hit) begin
                r_tmo <= r_tmo + 8'd1;
            end else begin
                r_tmo <= 8'd0;
            end
        end
    end

    // The timeout cycle drops cyc/stb to the slave and turns into an err
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        s_burst = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        o_owner = '0;
        unique case (r_state)
            OWN0: begin
                o_owner = 2'b01;
                s_cyc   = ~w_tmo_hit;
                s_stb   = m0_stb & ~w_tmo_hit;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_o;
                s_sel   = m0_sel;
                s_burst = r_blen;
                m0_ack  = s_ack & ~w_tmo_hit;
                m0_err  = s_err | w_tmo_hit;
            end
            OWN1: begin
                o_owner = 2'b10;
                s_cyc   = ~w_tmo_hit;
                s_stb   = m1_stb & ~w_tmo_hit;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_o;
                s_sel   = m1_sel;
                s_burst = r_blen;
                m1_ack  = s_ack & ~w_tmo_hit;
                m1_err  = s_err | w_tmo_hit;
            end
            default: begin
                o_owner = '0;
            end
        endcase
    end

    assign m0_dat_i = s_dat_i;
    assign m1_dat_i = s_dat_i;

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Directed bench for wb_burst_arbiter: master ack/err responses are
// queued by the stimulus and matched by a negedge monitor.
module tb_wb_burst_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_burst8 = 0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_dat_o = '0;
    logic [1:0]    m0_sel = '0;
    logic          m0_ack, m0_err;
    logic [DW-1:0] m0_dat_i;
    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic          m1_burst4 = 0, m1_burst8 = 0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_dat_o = '0;
    logic [1:0]    m1_sel = '0;
    logic          m1_ack, m1_err;
    logic [DW-1:0] m1_dat_i;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_o;
    logic [1:0]    s_sel, s_burst, o_owner;
    logic          s_ack = 0, s_err = 0;
    logic [DW-1:0] s_dat_i = '0;

    wb_burst_arbiter #(.AW(AW), .DW(DW), .TMO(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
        .m0_adr(m0_adr), .m0_dat_o(m0_dat_o), .m0_sel(m0_sel),
        .m0_burst8(m0_burst8),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_i(m0_dat_i),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_adr(m1_adr), .m1_dat_o(m1_dat_o), .m1_sel(m1_sel),
        .m1_burst4(m1_burst4), .m1_burst8(m1_burst8),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_i(m1_dat_i),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
        .s_burst(s_burst), .s_ack(s_ack), .s_err(s_err),
        .s_dat_i(s_dat_i), .o_owner(o_owner)
    );

    always #5 i_clk = ~i_clk;

    // response vector: {m0_ack, m0_err, m1_ack, m1_err}
    localparam logic [3:0] R_M0ACK = 4'b1000;
    localparam logic [3:0] R_M0ERR = 4'b0100;
    localparam logic [3:0] R_M1ACK = 4'b0010;
    localparam logic [3:0] R_M1ERR = 4'b0001;

    logic [3:0] exp_q[$];
    logic [3:0] mon_v;
    logic [3:0] mon_e;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        mon_v = {m0_ack, m0_err, m1_ack, m1_err};
        if (mon_v != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL resp_unexpected: got %b expected none", mon_v);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp", {28'd0, mon_v}, {28'd0, mon_e});
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ack_beats(input int n, input logic [3:0] e,
                             input logic [1:0] own);
        for (int i = 0; i < n; i++) begin
            s_ack = 1'b1;
            exp_q.push_back(e);
            @(negedge i_clk);
            chk("owner_in_burst", {30'd0, o_owner}, {30'd0, own});
            step();
        end
        s_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset: slave ack while held in reset must not reach a master
        s_ack = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("rst_owner", {30'd0, o_owner}, 32'd0);
        chk("rst_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_burst", {30'd0, s_burst}, 32'd0);
        step();
        s_ack = 1'b0;
        i_rst = 1'b1;
        step();

        // both masters request together, m0 8-beat wins first tie
        m0_cyc = 1; m0_stb = 1; m0_burst8 = 1;
        m1_cyc = 1; m1_stb = 1;
        step();
        @(negedge i_clk);
        chk("tie_owner", {30'd0, o_owner}, 32'd1);
        chk("tie_burst", {30'd0, s_burst}, 32'd2);
        chk("tie_cyc", {31'd0, s_cyc}, 32'd1);
        step();
        ack_beats(8, R_M0ACK, 2'b01);
        @(negedge i_clk);
        chk("gap_owner", {30'd0, o_owner}, 32'd0);
        chk("gap_cyc", {31'd0, s_cyc}, 32'd0);
        step();
        @(negedge i_clk);
        chk("rr_owner", {30'd0, o_owner}, 32'd2);
        chk("rr_burst", {30'd0, s_burst}, 32'd0);
        step();
        m0_cyc = 0; m0_stb = 0; m0_burst8 = 0;
        m1_cyc = 0; m1_stb = 0;
        step();
        @(negedge i_clk);
        chk("a_idle", {30'd0, o_owner}, 32'd0);
        chk("a_q", exp_q.size(), 32'd0);

        // m1 burst4+burst8 -> 8 beats; routing and latched length
        m0_adr = 24'h111111;
        m1_adr = 24'hABCDEF; m1_we = 1; m1_dat_o = 16'h5A5A;
        m1_sel = 2'b10; s_dat_i = 16'hBEEF;
        m1_cyc = 1; m1_stb = 1; m1_burst4 = 1; m1_burst8 = 1;
        step();
        @(negedge i_clk);
        chk("b_owner", {30'd0, o_owner}, 32'd2);
        chk("b_burst", {30'd0, s_burst}, 32'd2);
        chk("b_adr", {8'd0, s_adr}, 32'hABCDEF);
        chk("b_we", {31'd0, s_we}, 32'd1);
        chk("b_dat", {16'd0, s_dat_o}, 32'h5A5A);
        chk("b_sel", {30'd0, s_sel}, 32'd2);
        chk("b_m0dat", {16'd0, m0_dat_i}, 32'hBEEF);
        chk("b_m1dat", {16'd0, m1_dat_i}, 32'hBEEF);
        step();
        m1_burst8 = 0;
        @(negedge i_clk);
        chk("b_latched", {30'd0, s_burst}, 32'd2);
        step();
        ack_beats(8, R_M1ACK, 2'b10);
        m1_cyc = 0; m1_stb = 0; m1_burst4 = 0; m1_we = 0;
        @(negedge i_clk);
        chk("b_idle", {30'd0, o_owner}, 32'd0);
        chk("b_q", exp_q.size(), 32'd0);
        step();

        // m1 single: holds through 3 acks, releases after cyc drops
        m1_cyc = 1; m1_stb = 1;
        step();
        @(negedge i_clk);
        chk("c_burst", {30'd0, s_burst}, 32'd0);
        step();
        ack_beats(3, R_M1ACK, 2'b10);
        m1_stb = 0;
        repeat (2) begin
            @(negedge i_clk);
            chk("c_hold", {30'd0, o_owner}, 32'd2);
            step();
        end
        m1_cyc = 0;
        @(negedge i_clk);
        chk("c_drop", {30'd0, o_owner}, 32'd2);
        step();
        @(negedge i_clk);
        chk("c_idle", {30'd0, o_owner}, 32'd0);
        chk("c_q", exp_q.size(), 32'd0);
        step();

        // ack coincident with m0 cyc falling still reaches m0
        m0_cyc = 1; m0_stb = 1;
        step();
        m0_cyc = 0; s_ack = 1;
        exp_q.push_back(R_M0ACK);
        @(negedge i_clk);
        chk("d_owner", {30'd0, o_owner}, 32'd1);
        step();
        s_ack = 0; m0_stb = 0;
        @(negedge i_clk);
        chk("d_idle", {30'd0, o_owner}, 32'd0);
        step();

        // slave ack/err in idle are ignored
        s_ack = 1; s_err = 1;
        @(negedge i_clk);
        chk("e_m0ack", {31'd0, m0_ack}, 32'd0);
        chk("e_m1ack", {31'd0, m1_ack}, 32'd0);
        chk("e_m0err", {31'd0, m0_err}, 32'd0);
        step();
        s_ack = 0; s_err = 0;
        @(negedge i_clk);
        chk("e_idle", {30'd0, o_owner}, 32'd0);
        chk("e_q", exp_q.size(), 32'd0);
        step();

        // timeout: 4 stalled cycles then one err cycle with cyc low
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("f_stall_cyc", {31'd0, s_cyc}, 32'd1);
            step();
        end
        exp_q.push_back(R_M0ERR);
        @(negedge i_clk);
        chk("f_tmo_cyc", {31'd0, s_cyc}, 32'd0);
        chk("f_tmo_stb", {31'd0, s_stb}, 32'd0);
        step();
        m0_cyc = 0; m0_stb = 0;
        @(negedge i_clk);
        chk("f_idle", {30'd0, o_owner}, 32'd0);
        chk("f_q", exp_q.size(), 32'd0);
        step();

        // reset mid-burst: abandon, then a fresh grant counts 8 again
        m0_cyc = 1; m0_stb = 1; m0_burst8 = 1;
        step();
        ack_beats(3, R_M0ACK, 2'b01);
        i_rst = 0;
        #1;
        chk("g_rst_owner", {30'd0, o_owner}, 32'd0);
        chk("g_rst_cyc", {31'd0, s_cyc}, 32'd0);
        chk("g_rst_err", {31'd0, m0_err}, 32'd0);
        step();
        i_rst = 1;
        step();
        @(negedge i_clk);
        chk("g_regrant", {30'd0, o_owner}, 32'd1);
        step();
        ack_beats(8, R_M0ACK, 2'b01);
        m0_cyc = 0; m0_stb = 0; m0_burst8 = 0;
        @(negedge i_clk);
        chk("g_idle", {30'd0, o_owner}, 32'd0);
        step();

        // m1 4-beat burst, then m0 aborted by slave err
        m1_cyc = 1; m1_stb = 1; m1_burst4 = 1;
        step();
        @(negedge i_clk);
        chk("h_burst", {30'd0, s_burst}, 32'd1);
        step();
        ack_beats(4, R_M1ACK, 2'b10);
        m1_cyc = 0; m1_stb = 0; m1_burst4 = 0;
        @(negedge i_clk);
        chk("h_idle4", {30'd0, o_owner}, 32'd0);
        step();
        m0_cyc = 1; m0_stb = 1;
        step();
        s_err = 1;
        exp_q.push_back(R_M0ERR);
        @(negedge i_clk);
        chk("h_err_owner", {30'd0, o_owner}, 32'd1);
        step();
        s_err = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge i_clk);
        chk("h_idle_err", {30'd0, o_owner}, 32'd0);
        step();

        chk("final_q", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
